// File: rtl/regfile_mp.sv
// regfile_mp -- multi-port register file: one write port, three registered
// read ports sharing one read enable, a self-clearing INIT sweep and
// out-of-range address detection.
//
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a read port
// whose address matches the same-cycle in-range write returns the write data.
// When it is undefined, that port returns the pre-write contents.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset (restarts INIT)
//   we, waddr, wdata     write port
//   re                   read enable for all three read ports
//   raddr1..3            read addresses
//   rdata1..3            registered read data (held while re=0)
//   rvalid               one-cycle pulse qualifying rdata1..3
//   init_busy            high while the INIT sweep runs; ports are ignored
//   addr_err             one-cycle pulse after an access with address >= DEPTH
module regfile_mp #(
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic [ADDR_W-1:0] raddr3,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] rdata3,
    output logic              rvalid,
    output logic              init_busy,
    output logic              addr_err
);
    localparam int NRD = 3;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             ptr;
    logic [DATA_W-1:0]             mem [DEPTH];
    logic [NRD-1:0][ADDR_W-1:0]    raddr_v;
    logic [NRD-1:0][DATA_W-1:0]    rd_next;
    logic [NRD-1:0][DATA_W-1:0]    rdata_q;
    logic [NRD-1:0]                r_oor;
    logic                          ready;
    logic                          w_ok;

    assign raddr_v = {raddr3, raddr2, raddr1};
    assign ready   = (state_q == READY);
    assign w_ok    = ({1'b0, waddr} < DEPTH_L);

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    // FSM next state and status output
    always_comb begin
        state_d   = state_q;
        init_busy = 1'b0;
        case (state_q)
            INIT: begin
                init_busy = 1'b1;
                if (ptr == LAST) state_d = READY;
            end
            default: state_d = READY;
        endcase
    end

    // Read mux per port; out-of-range ports return zero.
    always_comb begin
        r_oor   = '0;
        rd_next = '0;
        for (int i = 0; i < NRD; i++) begin
            r_oor[i] = !({1'b0, raddr_v[i]} < DEPTH_L);
            if (!r_oor[i]) rd_next[i] = mem[raddr_v[i]];
`ifdef REGFILE_BYPASS_EN
            if (!r_oor[i] && we && w_ok && (raddr_v[i] == waddr))
                rd_next[i] = wdata;
`endif
        end
    end

    // Storage has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready)         mem[ptr]   <= INIT_VAL;
            else if (we && w_ok) mem[waddr] <= wdata;
        end
    end

    // Read registers, pulses and clear pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            rdata_q  <= '0;
            rvalid   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rvalid   <= ready && re;
            // A single pulse covers any combination of bad ports this cycle.
            addr_err <= ready && ((we && !w_ok) || (re && (|r_oor)));
            if (ready && re) rdata_q <= rd_next;
            if (!ready)      ptr     <= ptr + 1'b1;
        end
    end

    assign rdata1 = rdata_q[0];
    assign rdata2 = rdata_q[1];
    assign rdata3 = rdata_q[2];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- table-driven checks of regfile_mp (DEPTH=16, INIT_VAL=5A)
// plus hand sequences for INIT length, blocked ports during INIT, reset
// mid-INIT, and out-of-range handling on a DEPTH=12 instance.
module tb_regfile_mp;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst2 = 1'b1;
    logic       we = 1'b0;
    logic [3:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic       re = 1'b0;
    logic [3:0] raddr1 = '0, raddr2 = '0, raddr3 = '0;
    logic [7:0] rdata1, rdata2, rdata3;
    logic       rvalid, init_busy, addr_err;
    logic [7:0] q1, q2, q3;
    logic       qvalid, qbusy, qerr;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    regfile_mp #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .INIT_VAL(8'h5A)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
        .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
        .rvalid(rvalid), .init_busy(init_busy), .addr_err(addr_err));

    regfile_mp #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .INIT_VAL(8'h5A)) dut12 (
        .clk(clk), .rst(rst2), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr1(raddr1), .raddr2(raddr2), .raddr3(raddr3),
        .rdata1(q1), .rdata2(q2), .rdata3(q3),
        .rvalid(qvalid), .init_busy(qbusy), .addr_err(qerr));

`ifdef REGFILE_BYPASS_EN
    localparam logic [7:0] B9 = 8'h3C;
    localparam logic [7:0] BF = 8'hFF;
`else
    localparam logic [7:0] B9 = 8'h5A;
    localparam logic [7:0] BF = 8'h5A;
`endif

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [3:0] a1, a2, a3;
        logic       ev;
        logic [7:0] e1, e2, e3;
        logic       ee;
    } vec_t;

    vec_t tv [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_rd(input logic r, input logic [3:0] a1, input logic [3:0] a2,
                          input logic [3:0] a3);
        re = r; raddr1 = a1; raddr2 = a2; raddr3 = a3;
    endtask

    // Step while busy is high; returns the number of edges until it drops.
    task automatic count_busy(input bit use12, output int n);
        n = 0;
        while ((use12 ? qbusy : init_busy) && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        tv[0] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  4'd7,  4'd15, 1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0};
        tv[1] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  4'd0,  4'd0,  1'b0, 8'h5A, 8'h5A, 8'h5A, 1'b0};
        tv[2] = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  4'd0,  4'd0,  1'b0, 8'h5A, 8'h5A, 8'h5A, 1'b0};
        tv[3] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  4'd3,  4'd0,  1'b1, 8'hA5, 8'hA5, 8'h5A, 1'b0};
        tv[4] = '{1'b1, 4'd9,  8'h3C, 1'b1, 4'd9,  4'd3,  4'd0,  1'b1, B9,    8'hA5, 8'h5A, 1'b0};
        tv[5] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd9,  4'd9,  4'd9,  1'b1, 8'h3C, 8'h3C, 8'h3C, 1'b0};
        tv[6] = '{1'b1, 4'd15, 8'hFF, 1'b1, 4'd15, 4'd14, 4'd1,  1'b1, BF,    8'h5A, 8'h5A, 1'b0};
        tv[7] = '{1'b1, 4'd0,  8'h11, 1'b1, 4'd15, 4'd9,  4'd3,  1'b1, 8'hFF, 8'h3C, 8'hA5, 1'b0};
        tv[8] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  4'd0,  4'd0,  1'b1, 8'h11, 8'h11, 8'h11, 1'b0};
        tv[9] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  4'd0,  4'd0,  1'b0, 8'h11, 8'h11, 8'h11, 1'b0};

        // Reset state and INIT length
        step();
        chk("rst.busy", 32'(init_busy), 32'd1);
        chk("rst.rvalid", 32'(rvalid), 32'd0);
        chk("rst.err", 32'(addr_err), 32'd0);
        chk("rst.rdata1", 32'(rdata1), 32'd0);
        rst = 1'b0;
        count_busy(1'b0, n);
        chk("init.len", 32'(n), 32'd16);

        // Table: each vector is one cycle, checked after the edge
        for (int i = 0; i < 10; i++) begin
            we = tv[i].we; waddr = tv[i].wa; wdata = tv[i].wd;
            set_rd(tv[i].re, tv[i].a1, tv[i].a2, tv[i].a3);
            step();
            chk($sformatf("vec%0d.rvalid", i), 32'(rvalid), 32'(tv[i].ev));
            chk($sformatf("vec%0d.d1", i), 32'(rdata1), 32'(tv[i].e1));
            chk($sformatf("vec%0d.d2", i), 32'(rdata2), 32'(tv[i].e2));
            chk($sformatf("vec%0d.d3", i), 32'(rdata3), 32'(tv[i].e3));
            chk($sformatf("vec%0d.err", i), 32'(addr_err), 32'(tv[i].ee));
        end
        we = 1'b0; set_rd(1'b0, 4'd0, 4'd0, 4'd0);

        // Out-of-range handling on DEPTH=12
        rst2 = 1'b0;
        count_busy(1'b1, n);
        chk("d12.init.len", 32'(n), 32'd12);
        we = 1'b1; waddr = 4'd13; wdata = 8'h77;
        step();
        chk("d12.werr", 32'(qerr), 32'd1);
        we = 1'b0;
        step();
        chk("d12.werr.pulse", 32'(qerr), 32'd0);
        set_rd(1'b1, 4'd13, 4'd0, 4'd11);
        step();
        chk("d12.rd13", 32'(q1), 32'd0);
        chk("d12.rd0", 32'(q2), 32'h5A);
        chk("d12.rd11", 32'(q3), 32'h5A);
        chk("d12.rerr", 32'(qerr), 32'd1);
        chk("d12.rvalid", 32'(qvalid), 32'd1);
        set_rd(1'b1, 4'd13, 4'd14, 4'd1);
        step();
        chk("d12.multi.err", 32'(qerr), 32'd1);
        chk("d12.rd1", 32'(q3), 32'h5A);
        set_rd(1'b0, 4'd0, 4'd0, 4'd0);
        step();
        chk("d12.err.clear", 32'(qerr), 32'd0);

        // Ports blocked during INIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        we = 1'b1; waddr = 4'd4; wdata = 8'hEE;
        set_rd(1'b1, 4'd4, 4'd4, 4'd4);
        n = 0;
        while (init_busy && n < 100) begin
            chk("init.rvalid", 32'(rvalid), 32'd0);
            chk("init.err", 32'(addr_err), 32'd0);
            n++;
            step();
        end
        chk("init2.len", 32'(n), 32'd16);
        we = 1'b0;
        step();
        chk("init.blocked.d1", 32'(rdata1), 32'h5A);
        chk("init.blocked.rvalid", 32'(rvalid), 32'd1);
        set_rd(1'b0, 4'd0, 4'd0, 4'd0);

        // Reset during INIT at ptr=6
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();
        chk("midinit.busy", 32'(init_busy), 32'd1);
        rst = 1'b1;
        step();
        chk("midinit.d1", 32'(rdata1), 32'd0);
        rst = 1'b0;
        count_busy(1'b0, n);
        chk("midinit.len", 32'(n), 32'd16);

        // Reset together with a read request cancels the pulse
        set_rd(1'b1, 4'd2, 4'd2, 4'd2);
        step();
        chk("pre.rvalid", 32'(rvalid), 32'd1);
        rst = 1'b1;
        step();
        chk("rstrd.rvalid", 32'(rvalid), 32'd0);
        chk("rstrd.d1", 32'(rdata1), 32'd0);
        chk("rstrd.d3", 32'(rdata3), 32'd0);
        rst = 1'b0;
        set_rd(1'b0, 4'd0, 4'd0, 4'd0);
        count_busy(1'b0, n);
        chk("rstrd.len", 32'(n), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
